// File: rtl/regbus_if.sv
// Register-bus sequencer handshake: two requester command ports plus the
// register-file enables and external strobes driven by the controller.
interface regbus_if #(parameter int AW = 5);
  localparam int NREG = 2**AW;

  logic [1:0]      req;
  logic [1:0]      op0;
  logic [AW-1:0]   src0;
  logic [AW-1:0]   dst0;
  logic [1:0]      op1;
  logic [AW-1:0]   src1;
  logic [AW-1:0]   dst1;
  logic [1:0]      gnt;
  logic [1:0]      done;
  logic            busy;
  logic [NREG-1:0] rd;
  logic [NREG-1:0] wr;
  logic            ext_drv;
  logic            ext_cap;
  logic [7:0]      xfer_cnt;

  modport master (
    output req, op0, src0, dst0, op1, src1, dst1,
    input  gnt, done, busy, rd, wr, ext_drv, ext_cap, xfer_cnt
  );

  modport slave (
    input  req, op0, src0, dst0, op1, src1, dst1,
    output gnt, done, busy, rd, wr, ext_drv, ext_cap, xfer_cnt
  );
endinterface

// File: rtl/regbus_ctrl.sv
// Two-requester round-robin sequencer for the shared 8-bit register bus.
// IDLE -> SETUP (turnaround) -> XFER (one enable cycle) -> DONE.
module regbus_ctrl #(parameter int AW = 5) (
  input  logic    clk,
  input  logic    rst,
  regbus_if.slave bus
);
  localparam int NREG = 2**AW;
  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};
  localparam logic [1:0] OP_MOV = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2, OP_NOP = 2'd3;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;
  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
  } cmd_t;

  state_t          state, state_n;
  cmd_t            cmd, cmd_n;
  logic            win, win_n;
  logic            ptr, ptr_n;
  logic            k;
  logic [7:0]      cnt, cnt_n;
  logic [1:0]      gnt_q, gnt_n, done_q, done_n;
  logic [NREG-1:0] rd_q, rd_n, wr_q, wr_n;
  logic            drv_q, drv_n, cap_q, cap_n, busy_q;

  // ptr names the requester that wins a tie
  assign k = (bus.req == 2'b11) ? ptr : bus.req[1];

  always_comb begin
    state_n = state;
    cmd_n   = cmd;
    win_n   = win;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = '0;
    done_n  = '0;
    rd_n    = '0;
    wr_n    = '0;
    drv_n   = 1'b0;
    cap_n   = 1'b0;
    case (state)
      IDLE: if (bus.req != 2'b00) begin
        win_n   = k;
        cmd_n   = k ? cmd_t'{op: bus.op1, src: bus.src1, dst: bus.dst1}
                    : cmd_t'{op: bus.op0, src: bus.src0, dst: bus.dst0};
        gnt_n   = k ? 2'b10 : 2'b01;
        state_n = SETUP;
      end
      // enables are registered, so they are decoded here to appear in XFER
      SETUP: begin
        state_n = XFER;
        case (cmd.op)
          OP_MOV:   begin rd_n = ONE << cmd.src; wr_n = ONE << cmd.dst; end
          OP_LOAD:  begin drv_n = 1'b1;          wr_n = ONE << cmd.dst; end
          OP_STORE: begin rd_n = ONE << cmd.src; cap_n = 1'b1;          end
          default:  ;
        endcase
      end
      XFER: begin
        state_n = DONE;
        done_n  = win ? 2'b10 : 2'b01;
        ptr_n   = ~win;
        if (cmd.op != OP_NOP) cnt_n = cnt + 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cmd    <= '0;
      win    <= 1'b0;
      ptr    <= 1'b0;
      cnt    <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      drv_q  <= 1'b0;
      cap_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      cmd    <= cmd_n;
      win    <= win_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      gnt_q  <= gnt_n;
      done_q <= done_n;
      rd_q   <= rd_n;
      wr_q   <= wr_n;
      drv_q  <= drv_n;
      cap_q  <= cap_n;
      busy_q <= (state_n != IDLE);
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.rd       = rd_q;
  assign bus.wr       = wr_q;
  assign bus.ext_drv  = drv_q;
  assign bus.ext_cap  = cap_q;
  assign bus.xfer_cnt = cnt;
endmodule

// File: tb/tb_regbus_ctrl.sv
// Bench for regbus_ctrl: behavioural reg file and bus, vector table,
// directed corner sequences, random traffic with a per-cycle invariant monitor.
module tb_regbus_ctrl;
  localparam int AW = 5;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  always #5 clk = ~clk;

  regbus_if #(.AW(AW)) bus();
  regbus_ctrl #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;
  int inv_fail = 0;
  logic [1:0] pg;

  logic [7:0] mem [NREG];
  logic [7:0] ext_val, cap_val, busv;

  always_comb begin
    busv = 8'h00;
    for (int i = 0; i < NREG; i++) if (bus.rd[i]) busv = mem[i];
    if (bus.ext_drv) busv = ext_val;
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NREG; i++) mem[i] <= 8'(i * 7 + 1);
      mem[3]  <= 8'hA5;
      cap_val <= 8'h00;
    end else begin
      for (int i = 0; i < NREG; i++) if (bus.wr[i]) mem[i] <= busv;
      if (bus.ext_cap) cap_val <= busv;
    end
  end

  // enables are legal only in the cycle right after the grant pulse
  always @(negedge clk) begin
    if (rst) pg <= 2'b00;
    else begin
      if ($countones(bus.rd) > 1 || $countones(bus.wr) > 1 ||
          (bus.rd != 0 && bus.ext_drv) ||
          $countones(bus.gnt) > 1 || $countones(bus.done) > 1 ||
          ((bus.rd != 0 || bus.wr != 0 || bus.ext_drv || bus.ext_cap) && pg == 2'b00)) begin
        inv_fail <= inv_fail + 1;
        $display("FAIL invariant t=%0t rd=%h wr=%h drv=%b cap=%b gnt=%b done=%b",
                 $time, bus.rd, bus.wr, bus.ext_drv, bus.ext_cap, bus.gnt, bus.done);
      end
      pg <= bus.gnt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 20 && g == 2'b00; i++) begin @(posedge clk); #1; g = bus.gnt; end
  endtask

  task automatic wait_done(output logic [1:0] d);
    d = 2'b00;
    for (int i = 0; i < 20 && d == 2'b00; i++) begin @(posedge clk); #1; d = bus.done; end
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] op0; logic [4:0] src0, dst0;
    logic [1:0] op1; logic [4:0] src1, dst1;
    logic [1:0] e_gnt;
    logic [31:0] e_rd, e_wr;
    logic e_drv, e_cap;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vt [6];

  task automatic run_vec(input int n, input vec_t v);
    string s;
    s = $sformatf("v%0d", n);
    @(negedge clk);
    bus.op0 = v.op0; bus.src0 = v.src0; bus.dst0 = v.dst0;
    bus.op1 = v.op1; bus.src1 = v.src1; bus.dst1 = v.dst1;
    bus.req = v.req;
    @(posedge clk); #1;
    chk({s, "_gnt"}, 32'(bus.gnt), 32'(v.e_gnt));
    chk({s, "_busy"}, 32'(bus.busy), 32'd1);
    chk({s, "_setup_en"}, 32'(bus.rd | bus.wr), 32'd0);
    bus.req = 2'b00;
    @(posedge clk); #1;
    chk({s, "_rd"}, bus.rd, v.e_rd);
    chk({s, "_wr"}, bus.wr, v.e_wr);
    chk({s, "_drv"}, 32'(bus.ext_drv), 32'(v.e_drv));
    chk({s, "_cap"}, 32'(bus.ext_cap), 32'(v.e_cap));
    @(posedge clk); #1;
    chk({s, "_done"}, 32'(bus.done), 32'(v.e_gnt));
    chk({s, "_cnt"}, 32'(bus.xfer_cnt), 32'(v.e_cnt));
    @(posedge clk); #1;
    chk({s, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    logic [1:0] g, d;
    int ndone, c255;
    logic       havep;
    logic [1:0] p_op;
    logic [4:0] p_dst;
    logic [7:0] p_val;
    int nonnop, rnd_done;
    logic [7:0] cnt0;

    vt[0] = '{2'b01, 2'd0, 5'd3,  5'd7,  2'd3, 5'd0,  5'd0,  2'b01, 32'h8,        32'h80,       1'b0, 1'b0, 8'd1};
    vt[1] = '{2'b10, 2'd3, 5'd0,  5'd0,  2'd1, 5'd0,  5'd31, 2'b10, 32'h0,        32'h8000_0000, 1'b1, 1'b0, 8'd2};
    vt[2] = '{2'b01, 2'd2, 5'd31, 5'd0,  2'd3, 5'd0,  5'd0,  2'b01, 32'h8000_0000, 32'h0,        1'b0, 1'b1, 8'd3};
    vt[3] = '{2'b11, 2'd0, 5'd1,  5'd2,  2'd3, 5'd4,  5'd6,  2'b10, 32'h0,        32'h0,        1'b0, 1'b0, 8'd3};
    vt[4] = '{2'b11, 2'd0, 5'd5,  5'd5,  2'd0, 5'd8,  5'd12, 2'b01, 32'h20,       32'h20,       1'b0, 1'b0, 8'd4};
    vt[5] = '{2'b11, 2'd3, 5'd0,  5'd0,  2'd0, 5'd0,  5'd9,  2'b10, 32'h1,        32'h200,      1'b0, 1'b0, 8'd5};

    rst = 1'b1; mem_init = 1'b1; ext_val = 8'h3C;
    bus.req = 2'b00; bus.op0 = 2'd3; bus.src0 = '0; bus.dst0 = '0;
    bus.op1 = 2'd3; bus.src1 = '0; bus.dst1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt",  32'(bus.gnt), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rd",   bus.rd, 32'd0);
    chk("rst_wr",   bus.wr, 32'd0);
    chk("rst_ext",  32'({bus.ext_drv, bus.ext_cap}), 32'd0);
    chk("rst_cnt",  32'(bus.xfer_cnt), 32'd0);
    @(negedge clk); rst = 1'b0; mem_init = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec(i, vt[i]);
      if (i == 2) chk("store_cap", 32'(cap_val), 32'h3C);
    end
    chk("mem7",  32'(mem[7]),  32'hA5);
    chk("mem31", 32'(mem[31]), 32'h3C);
    chk("mem5",  32'(mem[5]),  32'h24);
    chk("mem9",  32'(mem[9]),  32'h01);

    // held req=11 alternates starting from requester 0
    do_reset();
    bus.op0 = 2'd0; bus.src0 = 5'd1; bus.dst0 = 5'd2;
    bus.op1 = 2'd0; bus.src1 = 5'd3; bus.dst1 = 5'd4;
    bus.req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_gnt(g);
      chk($sformatf("alt_gnt%0d", j), 32'(g), (j % 2 == 0) ? 32'd1 : 32'd2);
      wait_done(d);
      chk($sformatf("alt_done%0d", j), 32'(d), 32'(g));
    end
    bus.req = 2'b00;
    repeat (3) @(posedge clk);

    // NOP then 256 MOVs wrap the counter
    do_reset();
    bus.op0 = 2'd3; bus.req = 2'b01;
    wait_gnt(g);
    chk("nop_gnt", 32'(g), 32'd1);
    bus.req = 2'b00;
    wait_done(d);
    chk("nop_done", 32'(d), 32'd1);
    chk("nop_cnt", 32'(bus.xfer_cnt), 32'd0);
    @(negedge clk);
    bus.op0 = 2'd0; bus.src0 = 5'd8; bus.dst0 = 5'd9; bus.req = 2'b01;
    ndone = 0; c255 = -1;
    for (int i = 0; i < 256 * 4 + 40 && ndone < 256; i++) begin
      @(posedge clk); #1;
      if (bus.done != 2'b00) begin
        ndone++;
        if (ndone == 255) c255 = int'(bus.xfer_cnt);
        if (ndone == 256) bus.req = 2'b00;
      end
    end
    bus.req = 2'b00;
    chk("wrap_ndone", 32'(ndone), 32'd256);
    chk("wrap_c255", 32'(c255), 32'd255);
    chk("wrap_cnt", 32'(bus.xfer_cnt), 32'd0);
    repeat (3) @(posedge clk);

    // async reset in the middle of XFER
    @(negedge clk);
    bus.op0 = 2'd0; bus.src0 = 5'd2; bus.dst0 = 5'd5; bus.req = 2'b01;
    wait_gnt(g);
    bus.req = 2'b00;
    @(posedge clk); #1;
    chk("mid_rd", bus.rd, 32'h4);
    chk("mid_wr", bus.wr, 32'h20);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_rd", bus.rd, 32'd0);
    chk("mid_rst_wr", bus.wr, 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    bus.op0 = 2'd0; bus.src0 = 5'd6; bus.dst0 = 5'd7;
    bus.op1 = 2'd0; bus.src1 = 5'd10; bus.dst1 = 5'd11;
    bus.req = 2'b11;
    wait_gnt(g);
    chk("ptr_after_rst", 32'(g), 32'd1);
    bus.req = 2'b00;
    wait_done(d);
    @(negedge clk); bus.req = 2'b10;
    wait_gnt(g);
    chk("req10_gnt", 32'(g), 32'd2);
    bus.req = 2'b00;
    wait_done(d);
    chk("req10_done", 32'(d), 32'd2);

    // random traffic with a data scoreboard
    havep = 1'b0; p_op = '0; p_dst = '0; p_val = '0;
    nonnop = 0; rnd_done = 0;
    @(negedge clk);
    cnt0 = bus.xfer_cnt;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      if (bus.done != 2'b00 && havep) begin
        if (p_op == 2'd0 || p_op == 2'd1) chk("rnd_data", 32'(mem[p_dst]), 32'(p_val));
        if (p_op != 2'd3) nonnop++;
        rnd_done++;
        havep = 1'b0;
      end
      if (bus.gnt != 2'b00) begin
        if (bus.gnt[1]) begin p_op = bus.op1; p_dst = bus.dst1; p_val = (bus.op1 == 2'd0) ? mem[bus.src1] : ext_val; end
        else            begin p_op = bus.op0; p_dst = bus.dst0; p_val = (bus.op0 == 2'd0) ? mem[bus.src0] : ext_val; end
        havep = 1'b1;
        bus.req = bus.req & ~bus.gnt;
      end
      if (!havep && !bus.busy) ext_val = 8'($urandom);
      if (!bus.req[0] && $urandom_range(3) == 0) begin
        bus.op0 = 2'($urandom); bus.src0 = 5'($urandom); bus.dst0 = 5'($urandom); bus.req[0] = 1'b1;
      end
      if (!bus.req[1] && $urandom_range(3) == 0) begin
        bus.op1 = 2'($urandom); bus.src1 = 5'($urandom); bus.dst1 = 5'($urandom); bus.req[1] = 1'b1;
      end
    end
    bus.req = 2'b00;
    repeat (6) @(negedge clk);
    if (havep && (p_op == 2'd0 || p_op == 2'd1)) begin
      chk("rnd_data_last", 32'(mem[p_dst]), 32'(p_val));
      if (p_op != 2'd3) nonnop++;
    end else if (havep && p_op == 2'd2) nonnop++;
    chk("rnd_activity", 32'(rnd_done > 100), 32'd1);
    chk("rnd_cnt", 32'(bus.xfer_cnt), 32'(8'(cnt0 + 8'(nonnop))));
    chk("invariants", 32'(inv_fail), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
